// File: rtl/uart_echo_fifo_if.sv
// rtl/uart_echo_fifo_if.sv - stream handshake bundle for the echo buffer
// Ports:
//   tdata   word carried on the stream
//   tvalid  producer holds a word
//   tready  consumer accepts the word
//   master  drives tdata/tvalid, samples tready
//   slave   samples tdata/tvalid, drives tready
interface uart_echo_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART echo buffer: FIFO, output transform, statistics
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   input_axis    slave stream from the uart receiver
//   output_axis   master stream to the uart transmitter (registered)
//   mode          0 pass, 1 invert, 2 bit-reverse, 3 ASCII upper-case
//   clear         one-cycle pulse zeroing counters and overflow
//   fifo_level    RAM occupancy plus output-register valid
//   rx_count, tx_count, drop_count, overflow   statistics
module uart_echo_fifo #(
   parameter int DATA_WIDTH     = 8,
   parameter int DEPTH          = 16,
   parameter int DROP_WHEN_FULL = 1,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   uart_echo_fifo_if.slave            input_axis,
   uart_echo_fifo_if.master           output_axis,
   input  logic [1:0]                 mode,
   input  logic                       clear,
   output logic [$clog2(DEPTH)+1:0]   fifo_level,
   output logic [COUNT_WIDTH-1:0]     rx_count,
   output logic [COUNT_WIDTH-1:0]     tx_count,
   output logic [COUNT_WIDTH-1:0]     drop_count,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [DATA_WIDTH-1:0] LC_A       = DATA_WIDTH'(8'h61);
   localparam logic [DATA_WIDTH-1:0] LC_Z       = DATA_WIDTH'(8'h7A);
   localparam logic [DATA_WIDTH-1:0] CASE_DELTA = DATA_WIDTH'(8'h20);

   logic [DATA_WIDTH-1:0]  ram_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic [COUNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
   logic [COUNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic                   ovf_q, ovf_d;

   logic full, empty, in_ready, wr_en, drop_en, ld_en, tx_hs;

   function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                   input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      r = w;
      case (m)
         2'd1: r = ~w;
         2'd2: for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[DATA_WIDTH-1-i];
         2'd3: if (DATA_WIDTH == 8 && w >= LC_A && w <= LC_Z) r = w - CASE_DELTA;
         default: r = w;
      endcase
      return r;
   endfunction

   // Full when the pointers address the same slot but sit on different laps.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign in_ready = (DROP_WHEN_FULL != 0) ? 1'b1 : !full;
   assign wr_en    = input_axis.tvalid && in_ready && !full;
   assign drop_en  = (DROP_WHEN_FULL != 0) && input_axis.tvalid && full;
   assign ld_en    = (!out_valid_q || output_axis.tready) && !empty;
   assign tx_hs    = out_valid_q && output_axis.tready;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      // The transform sees mode only on the load cycle, so a held word never changes.
      if (ld_en) begin
         out_data_d  = xform(mode, ram_q[rd_ptr_q[AW-1:0]]);
         out_valid_d = 1'b1;
         rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (output_axis.tready) begin
         out_valid_d = 1'b0;
      end
      // clear wins over any increment landing on the same edge.
      rx_cnt_d   = clear ? '0 : rx_cnt_q + COUNT_WIDTH'(wr_en);
      tx_cnt_d   = clear ? '0 : tx_cnt_q + COUNT_WIDTH'(tx_hs);
      drop_cnt_d = clear ? '0 : drop_cnt_q + COUNT_WIDTH'(drop_en);
      ovf_d      = clear ? 1'b0 : (ovf_q || drop_en);
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram_q[wr_ptr_q[AW-1:0]] <= input_axis.tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         rx_cnt_q    <= '0;
         tx_cnt_q    <= '0;
         drop_cnt_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_cnt_q    <= tx_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign input_axis.tready  = in_ready;
   assign output_axis.tdata  = out_data_q;
   assign output_axis.tvalid = out_valid_q;
   assign fifo_level = {1'b0, wr_ptr_q - rd_ptr_q} + {{PW{1'b0}}, out_valid_q};
   assign rx_count   = rx_cnt_q;
   assign tx_count   = tx_cnt_q;
   assign drop_count = drop_cnt_q;
   assign overflow   = ovf_q;
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART echo buffer between the receive AXI-stream output of a `uart` instance and the transmit AXI-stream input of the same or another instance. Received words are buffered in a DEPTH-entry FIFO, so reception never stalls while the transmitter is busy. Each word passes through a selectable transform on its way out. Receive, transmit and drop counters plus a sticky overflow flag are exposed for LEDs and debug.

## Interface
- DATA_WIDTH, 8: word width (matches uart data width).
- DEPTH, 16: FIFO RAM entries; power of two, ≥2.
- DROP_WHEN_FULL, 1: 1 = always accept input and discard when full; 0 = backpressure input.
- COUNT_WIDTH, 16: width of the statistics counters.
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- input_axis_tdata  in  DATA_WIDTH  word from uart receiver.
- input_axis_tvalid  in  1  word valid.
- input_axis_tready  out  1  DROP_WHEN_FULL=1: constant 1; otherwise !full (combinational).
- output_axis_tdata  out  DATA_WIDTH  transformed word to uart transmitter (registered).
- output_axis_tvalid  out  1  output register holds a word.
- output_axis_tready  in  1  transmitter accepts.
- mode  in  2  transform: 0 pass, 1 bitwise invert, 2 bit-reverse, 3 ASCII upper-case.
- clear  in  1  one-cycle pulse; zeroes counters and overflow; FIFO contents are kept.
- fifo_level  out  $clog2(DEPTH)+2  RAM occupancy plus output-register valid.
- rx_count, tx_count, drop_count  out  COUNT_WIDTH each  statistics.
- overflow  out  1  sticky; set on the first dropped word.

## Operation
- Storage: DEPTH-entry RAM with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits. Full = pointers differ only in the MSB. Empty = pointers are equal. Pointers wrap modulo 2·DEPTH.
- Write: on input_axis_tvalid && input_axis_tready && !full, store the word, increment wr_ptr and rx_count.
- Drop (DROP_WHEN_FULL=1): on input_axis_tvalid && full, discard the word, increment drop_count and set overflow. rx_count is not incremented.
- Output register load: when (!output_axis_tvalid || output_axis_tready) && !empty:
  - load xform(ram[rd_ptr]), increment rd_ptr, set output_axis_tvalid.
  - If the register is consumed and the FIFO is empty, clear output_axis_tvalid.
- The output word is held stable while tvalid && !tready.
- Transform is applied at load time using the mode value sampled on the load cycle. A later mode change does not alter words already loaded.
  - Mode 3: for DATA_WIDTH=8 and word in 0x61..0x7A, subtract 0x20; otherwise pass unchanged. For DATA_WIDTH≠8, mode 3 behaves as pass.
- Simultaneous write and read of the FIFO: both occur, and the level is unchanged.
- Writing into an empty FIFO is not bypassed; the word is first written to RAM.
- tx_count increments on each output handshake.
- Counters wrap modulo 2^COUNT_WIDTH.
- clear has priority over any increment in the same cycle: the counter reads 0 after that edge.
- Reset: all pointers, counters, overflow and output_axis_tvalid go to 0 immediately; output_axis_tdata resets to 0. Reset mid-transfer discards all buffered words. input_axis_tready reads 1 during and after reset.

## Timing
- Latency: a word accepted at edge k into an empty FIFO with an idle output shows output_axis_tvalid=1 after edge k+1.
- Throughput: one word per cycle sustained in both directions.
- fifo_level updates on the edge following each event; maximum value is DEPTH+1.
- With DROP_WHEN_FULL=0, input_axis_tready falls in the same cycle full is reached, i.e. after the write edge that fills the RAM.
- No combinational path from output_axis_tready to output_axis_tdata or output_axis_tvalid.

## Test plan
- Reset release, mode=0: send 0x41 with output_axis_tready=1 → output_axis_tvalid high 2 cycles after acceptance, data 0x41; rx_count=tx_count=1.
- mode=3: send 0x61, 0x7A, 0x5B → output 0x41, 0x5A, 0x5B. mode=1: send 0x0F → 0xF0. mode=2: send 0x01 → 0x80.
- DEPTH=16, DROP_WHEN_FULL=1, output_axis_tready=0: send 20 words 0x00..0x13 → fifo_level=17, drop_count=3, overflow=1. Release tready → outputs 0x00..0x10 in order, tx_count=17.
- DROP_WHEN_FULL=0, same stimulus → input_axis_tready low once RAM is full; no words lost; drop_count=0. After draining, all 20 words appear in order.
- Pulse clear in the same cycle as an input accept → rx_count=0 after that edge, overflow=0, fifo_level unchanged.
- Assert rst_n=0 asynchronously (mid-clock) with 5 words buffered → output_axis_tvalid=0 and fifo_level=0 before the next clock edge. After release, the next input word is the first one output.
